// File: rtl/ram_cmd_arbiter_if.sv
// rtl/ram_cmd_arbiter_if.sv - requester, response and RAM-side signal bundle for ram_cmd_arbiter
interface ram_cmd_arbiter_if;
    logic       req0_valid;
    logic [9:0] req0_din;
    logic       req0_ready;
    logic       req1_valid;
    logic [9:0] req1_din;
    logic       req1_ready;
    logic       rsp0_valid;
    logic [7:0] rsp0_data;
    logic       rsp1_valid;
    logic [7:0] rsp1_data;
    logic       rsp_err;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;
    logic       owner;
    logic       busy;
    logic       lock_timeout;

    modport slave (
        input  req0_valid, req0_din, req1_valid, req1_din, ram_dout, ram_tx_valid,
        output req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
               rsp_err, ram_din, ram_rx_valid, owner, busy, lock_timeout
    );

    modport master (
        output req0_valid, req0_din, req1_valid, req1_din, ram_dout, ram_tx_valid,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
               rsp_err, ram_din, ram_rx_valid, owner, busy, lock_timeout
    );
endinterface

// File: rtl/ram_cmd_arbiter.sv
// rtl/ram_cmd_arbiter.sv - two-requester RAM command arbiter with address lock and read-response routing
module ram_cmd_arbiter #(
    parameter int LOCK_TIMEOUT = 16,
    parameter int RSP_TIMEOUT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_cmd_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOCKED, WAIT_RSP} state_e;

    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam int RW = $clog2(RSP_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic            owner_q, owner_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [RW-1:0]   rsp_cnt_q, rsp_cnt_d;
    logic [9:0]      ram_din_q, ram_din_d;
    logic            ram_rx_valid_q, ram_rx_valid_d;
    logic            rsp0_valid_q, rsp0_valid_d;
    logic            rsp1_valid_q, rsp1_valid_d;
    logic [7:0]      rsp0_data_q, rsp0_data_d;
    logic [7:0]      rsp1_data_q, rsp1_data_d;
    logic            rsp_err_q, rsp_err_d;
    logic            lock_timeout_q, lock_timeout_d;

    logic            ready0, ready1, acc, acc_id, rsp_done;
    logic [9:0]      acc_word;

    // IDLE arbitrates on valid; LOCKED hands ready to the owner unconditionally.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        case (state_q)
            IDLE: begin
                ready0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
                ready1 = bus.req1_valid && (!bus.req0_valid || rr_q);
            end
            LOCKED: begin
                ready0 = !owner_q;
                ready1 = owner_q;
            end
            default: ;
        endcase
    end

    assign acc      = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);
    assign acc_id   = bus.req1_valid && ready1;
    assign acc_word = acc_id ? bus.req1_din : bus.req0_din;
    assign rsp_done = bus.ram_tx_valid || (rsp_cnt_q == RW'(RSP_TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        owner_d        = owner_q;
        lock_cnt_d     = lock_cnt_q;
        rsp_cnt_d      = rsp_cnt_q;
        ram_din_d      = ram_din_q;
        ram_rx_valid_d = 1'b0;
        rsp0_valid_d   = 1'b0;
        rsp1_valid_d   = 1'b0;
        rsp0_data_d    = rsp0_data_q;
        rsp1_data_d    = rsp1_data_q;
        rsp_err_d      = 1'b0;
        lock_timeout_d = 1'b0;

        // An accepted word always wins over a lock expiry in the same cycle.
        if (acc) begin
            ram_din_d      = acc_word;
            ram_rx_valid_d = 1'b1;
            owner_d        = acc_id;
            case (acc_word[9:8])
                2'b01: begin
                    state_d = IDLE;
                    rr_d    = !acc_id;
                end
                2'b11: begin
                    state_d   = WAIT_RSP;
                    rsp_cnt_d = '0;
                end
                default: begin
                    state_d    = LOCKED;
                    lock_cnt_d = '0;
                end
            endcase
        end else begin
            case (state_q)
                LOCKED: begin
                    if (lock_cnt_q == LW'(LOCK_TIMEOUT - 1)) begin
                        state_d        = IDLE;
                        lock_timeout_d = 1'b1;
                        rr_d           = !owner_q;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LW'(1);
                    end
                end
                WAIT_RSP: begin
                    if (rsp_done) begin
                        state_d      = IDLE;
                        rr_d         = !owner_q;
                        rsp_err_d    = !bus.ram_tx_valid;
                        rsp0_valid_d = !owner_q;
                        rsp1_valid_d = owner_q;
                        if (owner_q) rsp1_data_d = bus.ram_tx_valid ? bus.ram_dout : 8'h00;
                        else         rsp0_data_d = bus.ram_tx_valid ? bus.ram_dout : 8'h00;
                    end else begin
                        rsp_cnt_d = rsp_cnt_q + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_q           <= 1'b0;
            owner_q        <= 1'b0;
            lock_cnt_q     <= '0;
            rsp_cnt_q      <= '0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
            rsp0_data_q    <= '0;
            rsp1_data_q    <= '0;
            rsp_err_q      <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            owner_q        <= owner_d;
            lock_cnt_q     <= lock_cnt_d;
            rsp_cnt_q      <= rsp_cnt_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            rsp0_valid_q   <= rsp0_valid_d;
            rsp1_valid_q   <= rsp1_valid_d;
            rsp0_data_q    <= rsp0_data_d;
            rsp1_data_q    <= rsp1_data_d;
            rsp_err_q      <= rsp_err_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.rsp0_valid   = rsp0_valid_q;
    assign bus.rsp1_valid   = rsp1_valid_q;
    assign bus.rsp0_data    = rsp0_data_q;
    assign bus.rsp1_data    = rsp1_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.ram_din      = ram_din_q;
    assign bus.ram_rx_valid = ram_rx_valid_q;
    assign bus.owner        = owner_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.lock_timeout = lock_timeout_q;
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// tb/tb_ram_cmd_arbiter.sv - directed and randomized checks of ram_cmd_arbiter against a deadline-based model
module tb_ram_cmd_arbiter;
    localparam int LT = 16;
    localparam int RT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_cmd_arbiter_if bus();
    ram_cmd_arbiter #(.LOCK_TIMEOUT(LT), .RSP_TIMEOUT(RT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: mode 0 idle / 1 locked / 2 awaiting read data; expiry tracked as absolute cycle numbers.
    int         m_mode = 0;
    bit         m_rr = 0, m_owner = 0;
    int         lock_dl = 0, rsp_dl = 0;
    bit         e_rxv = 0, e_err = 0, e_lto = 0;
    logic [9:0] e_din = '0;
    bit         e_rv0 = 0, e_rv1 = 0;
    logic [7:0] e_rd0 = '0, e_rd1 = '0;

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_in(bit v0, logic [9:0] d0, bit v1, logic [9:0] d1,
                          bit txv, logic [7:0] dout, bit rn);
        bus.req0_valid   = v0;
        bus.req0_din     = d0;
        bus.req1_valid   = v1;
        bus.req1_din     = d1;
        bus.ram_tx_valid = txv;
        bus.ram_dout     = dout;
        rst_n            = rn;
    endtask

    task automatic tick();
        bit er0, er1, a0, a1, id;
        logic [9:0] w;
        #1;
        er0 = 0; er1 = 0;
        if (m_mode == 0) begin
            er0 = bus.req0_valid && (!bus.req1_valid || !m_rr);
            er1 = bus.req1_valid && (!bus.req0_valid || m_rr);
        end else if (m_mode == 1) begin
            er0 = !m_owner;
            er1 = m_owner;
        end
        check("req0_ready",   16'(bus.req0_ready),   16'(er0));
        check("req1_ready",   16'(bus.req1_ready),   16'(er1));
        check("ram_rx_valid", 16'(bus.ram_rx_valid), 16'(e_rxv));
        check("ram_din",      16'(bus.ram_din),      16'(e_din));
        check("rsp0_valid",   16'(bus.rsp0_valid),   16'(e_rv0));
        check("rsp1_valid",   16'(bus.rsp1_valid),   16'(e_rv1));
        check("rsp0_data",    16'(bus.rsp0_data),    16'(e_rd0));
        check("rsp1_data",    16'(bus.rsp1_data),    16'(e_rd1));
        check("rsp_err",      16'(bus.rsp_err),      16'(e_err));
        check("owner",        16'(bus.owner),        16'(m_owner));
        check("busy",         16'(bus.busy),         16'(m_mode != 0));
        check("lock_timeout", 16'(bus.lock_timeout), 16'(e_lto));

        if (!rst_n) begin
            m_mode = 0; m_rr = 0; m_owner = 0;
            e_rxv = 0; e_din = '0; e_rv0 = 0; e_rv1 = 0;
            e_rd0 = '0; e_rd1 = '0; e_err = 0; e_lto = 0;
        end else begin
            e_rxv = 0; e_rv0 = 0; e_rv1 = 0; e_err = 0; e_lto = 0;
            a0 = bus.req0_valid && er0;
            a1 = bus.req1_valid && er1;
            if (a0 || a1) begin
                id = a1;
                w  = a1 ? bus.req1_din : bus.req0_din;
                e_din = w; e_rxv = 1; m_owner = id;
                if (w[9:8] == 2'b01) begin
                    m_mode = 0; m_rr = !id;
                end else if (w[9:8] == 2'b11) begin
                    m_mode = 2; rsp_dl = cyc + RT;
                end else begin
                    m_mode = 1; lock_dl = cyc + LT;
                end
            end else if (m_mode == 1 && cyc == lock_dl) begin
                m_mode = 0; e_lto = 1; m_rr = !m_owner;
            end else if (m_mode == 2 && (bus.ram_tx_valid || cyc == rsp_dl)) begin
                e_err = !bus.ram_tx_valid;
                if (m_owner) begin e_rv1 = 1; e_rd1 = bus.ram_tx_valid ? bus.ram_dout : 8'h00; end
                else         begin e_rv0 = 1; e_rd0 = bus.ram_tx_valid ? bus.ram_dout : 8'h00; end
                m_mode = 0; m_rr = !m_owner;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(bit v0, logic [9:0] d0, bit v1, logic [9:0] d1,
                         bit txv = 0, logic [7:0] dout = 8'h00, bit rn = 1);
        set_in(v0, d0, v1, d1, txv, dout, rn);
        tick();
    endtask

    initial begin
        set_in(0, '0, 0, '0, 0, '0, 0);
        @(negedge clk);
        drive(0, '0, 0, '0, 0, 8'h00, 0);
        drive(0, '0, 0, '0, 0, 8'h00, 0);
        check("rst_busy", 16'(bus.busy), 16'h0);
        check("rst_din",  16'(bus.ram_din), 16'h0);

        // req0 write pair, then rr must favour req1
        drive(1, 10'h005, 0, '0);
        check("d031_busy", 16'(bus.busy), 16'h1);
        drive(1, 10'h1AB, 0, '0);
        check("d031_din", 16'(bus.ram_din), 16'h1AB);
        set_in(1, 10'h100, 1, 10'h100, 0, 8'h00, 1);
        #1;
        check("d031_rr", 16'(bus.req1_ready), 16'h1);
        tick();

        // both valid, rr=0: req0 read runs to completion first
        drive(1, 10'h210, 1, 10'h000);
        drive(1, 10'h300, 1, 10'h000);
        drive(0, '0, 1, 10'h000);
        drive(0, '0, 1, 10'h000, 1, 8'h33);
        set_in(0, '0, 1, 10'h000, 0, 8'h00, 1);
        #1;
        check("d032_rsp0", 16'(bus.rsp0_valid), 16'h1);
        check("d032_grant1", 16'(bus.req1_ready), 16'h1);
        tick();
        drive(0, '0, 1, 10'h100);

        // req1 read, RAM answers at N+2
        drive(0, '0, 1, 10'h2FF);
        drive(0, '0, 1, 10'h300);
        drive(0, '0, 0, '0);
        drive(0, '0, 0, '0, 1, 8'h5A);
        check("d033_v1", 16'(bus.rsp1_valid), 16'h1);
        check("d033_d1", 16'(bus.rsp1_data), 16'h5A);
        check("d033_v0", 16'(bus.rsp0_valid), 16'h0);
        drive(0, '0, 0, '0);

        // lock expiry with req1 waiting
        drive(1, 10'h020, 1, 10'h100);
        for (int i = 0; i < LT; i++) drive(0, '0, 1, 10'h100);
        check("d034_lto", 16'(bus.lock_timeout), 16'h1);
        check("d034_busy", 16'(bus.busy), 16'h0);
        drive(0, '0, 1, 10'h100);
        check("d034_owner", 16'(bus.owner), 16'h1);

        // word on the expiry cycle wins
        drive(0, '0, 1, 10'h0AA);
        for (int i = 0; i < LT - 1; i++) drive(0, '0, 0, '0);
        drive(0, '0, 1, 10'h155);
        check("d028_lto", 16'(bus.lock_timeout), 16'h0);
        check("d028_din", 16'(bus.ram_din), 16'h155);

        // response timeout
        drive(1, 10'h300, 0, '0);
        for (int i = 0; i < RT; i++) drive(0, '0, 0, '0);
        check("d035_v0", 16'(bus.rsp0_valid), 16'h1);
        check("d035_err", 16'(bus.rsp_err), 16'h1);
        check("d035_d0", 16'(bus.rsp0_data), 16'h0);

        // reset while waiting discards the read
        drive(0, '0, 1, 10'h300);
        drive(0, '0, 0, '0, 0, 8'h00, 0);
        drive(0, '0, 0, '0, 1, 8'h77);
        drive(0, '0, 0, '0, 1, 8'h77);
        check("d036_v1", 16'(bus.rsp1_valid), 16'h0);
        check("d036_busy", 16'(bus.busy), 16'h0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1) == 1, 10'($urandom),
                  $urandom_range(0, 1) == 1, 10'($urandom),
                  $urandom_range(0, 3) == 0, 8'($urandom),
                  $urandom_range(0, 199) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
